// File: rtl/disp_sched.sv
// Display scheduler: arbitrates keypad echo, ALU result and error status onto
// the shared seven-segment display with min-hold, idle-blank and error blink.
module disp_sched #(
    parameter int W         = 36,
    parameter int HOLD_CYC  = 16,
    parameter int IDLE_CYC  = 1024,
    parameter int BLINK_CYC = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         ent_valid,
    output logic         ent_ready,
    input  logic [W-1:0] ent_data,
    input  logic         res_valid,
    output logic         res_ready,
    input  logic [W-1:0] res_data,
    input  logic         res_div0,
    input  logic         err_valid,
    output logic         err_ready,
    output logic [W-1:0] disp_binary,
    output logic         disp_div0,
    output logic         disp_en,
    output logic [1:0]   owner
);

    localparam int HW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
    localparam int IW = (IDLE_CYC  > 1) ? $clog2(IDLE_CYC)  : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_ENT  = 2'd1;
    localparam logic [1:0] ID_RES  = 2'd2;
    localparam logic [1:0] ID_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  disp_binary_q, disp_binary_d;
    logic          disp_div0_q, disp_div0_d;
    logic          disp_en_q, disp_en_d;
    logic [1:0]    owner_q, owner_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    logic elig_ent, elig_res, elig_err;
    logic req_ent, req_res, req_err;
    logic acc_ent, acc_res, acc_err;
    logic xfer;

    // A requester may take the display when it is free, the hold has expired,
    // it outranks the current owner, or it already owns it.
    always_comb begin
        elig_ent = (owner_q == ID_NONE) || (hold_cnt_q == '0) ||
                   (ID_ENT > owner_q) || (owner_q == ID_ENT);
        elig_res = (owner_q == ID_NONE) || (hold_cnt_q == '0) ||
                   (ID_RES > owner_q) || (owner_q == ID_RES);
        elig_err = (owner_q == ID_NONE) || (hold_cnt_q == '0) ||
                   (ID_ERR > owner_q) || (owner_q == ID_ERR);

        req_err = err_valid & elig_err;
        req_res = res_valid & elig_res;
        req_ent = ent_valid & elig_ent;

        acc_err = req_err & ~clear & ~reset;
        acc_res = req_res & ~req_err & ~clear & ~reset;
        acc_ent = req_ent & ~req_res & ~req_err & ~clear & ~reset;
        xfer    = acc_err | acc_res | acc_ent;
    end

    always_comb begin
        state_d       = state_q;
        disp_binary_d = disp_binary_q;
        disp_div0_d   = disp_div0_q;
        disp_en_d     = disp_en_q;
        owner_d       = owner_q;
        hold_cnt_d    = hold_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        blink_cnt_d   = blink_cnt_q;

        if (clear) begin
            state_d       = ST_BLANK;
            disp_binary_d = '0;
            disp_div0_d   = 1'b0;
            disp_en_d     = 1'b0;
            owner_d       = ID_NONE;
            hold_cnt_d    = '0;
            idle_cnt_d    = '0;
            blink_cnt_d   = '0;
        end else if (xfer) begin
            hold_cnt_d  = HW'(HOLD_CYC - 1);
            idle_cnt_d  = IW'(IDLE_CYC - 1);
            blink_cnt_d = BW'(BLINK_CYC - 1);
            disp_en_d   = 1'b1;
            if (acc_err) begin
                disp_div0_d = 1'b1;
                state_d     = ST_ERR;
                owner_d     = ID_ERR;
            end else if (acc_res) begin
                disp_binary_d = res_data;
                disp_div0_d   = res_div0;
                state_d       = res_div0 ? ST_ERR : ST_SHOW;
                owner_d       = ID_RES;
            end else begin
                disp_binary_d = ent_data;
                disp_div0_d   = 1'b0;
                state_d       = ST_SHOW;
                owner_d       = ID_ENT;
            end
        end else begin
            hold_cnt_d = (hold_cnt_q == '0) ? '0 : hold_cnt_q - 1'b1;
            case (state_q)
                ST_SHOW: begin
                    if (idle_cnt_q == '0) begin
                        state_d   = ST_BLANK;
                        disp_en_d = 1'b0;
                        owner_d   = ID_NONE;
                    end else begin
                        idle_cnt_d = idle_cnt_q - 1'b1;
                    end
                end
                ST_ERR: begin
                    if (blink_cnt_q == '0) begin
                        disp_en_d   = ~disp_en_q;
                        blink_cnt_d = BW'(BLINK_CYC - 1);
                    end else begin
                        blink_cnt_d = blink_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            disp_binary_q <= '0;
            disp_div0_q   <= 1'b0;
            disp_en_q     <= 1'b0;
            owner_q       <= ID_NONE;
            hold_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            blink_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            disp_binary_q <= disp_binary_d;
            disp_div0_q   <= disp_div0_d;
            disp_en_q     <= disp_en_d;
            owner_q       <= owner_d;
            hold_cnt_q    <= hold_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
        end
    end

    assign ent_ready   = acc_ent;
    assign res_ready   = acc_res;
    assign err_ready   = acc_err;
    assign disp_binary = disp_binary_q;
    assign disp_div0   = disp_div0_q;
    assign disp_en     = disp_en_q;
    assign owner       = owner_q;

endmodule
